// File: rtl/vga_timing_decoder.sv
// VGA timing decoder: recovers pixel/line position from hsync/vsync edges,
// measures line and frame lengths, and locks after consecutive matching frames.
module vga_timing_decoder #(
    parameter int H_TOTAL      = 1056,
    parameter int V_TOTAL      = 628,
    parameter int H_SYNC_START = 840,
    parameter int V_SYNC_START = 601,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic        frame_tick,
    output logic        locked,
    output logic        sync_err
);

    localparam int TO_LIMIT = 2 * H_TOTAL;
    localparam int TO_W     = $clog2(TO_LIMIT + 2);
    localparam int GC_W     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'd2047) ? v : v + 11'd1;
    endfunction

    logic            hs_d_r;
    logic            vs_d_r;
    logic            h_seen_r;
    logic            v_seen_r;
    logic            frame_bad_r;
    logic [10:0]     cyc_cnt_r;
    logic [10:0]     line_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [GC_W-1:0] good_cnt_r;
    state_t          state_r;

    logic        hs_edge_s;
    logic        vs_edge_s;
    logic        h_wrap_s;
    logic        timeout_s;
    logic        line_bad_s;
    logic        frame_bad_s;
    logic [10:0] lines_s;

    assign hs_edge_s   = hsync_in & ~hs_d_r;
    assign vs_edge_s   = vsync_in & ~vs_d_r;
    assign h_wrap_s    = ~hs_edge_s & (hcount_out == 11'(H_TOTAL - 1));
    // Separate wide counter: the timeout exceeds the 2047 saturation of cyc_cnt_r.
    assign timeout_s   = h_seen_r & ~hs_edge_s & (to_cnt_r == TO_W'(TO_LIMIT));
    assign line_bad_s  = (hs_edge_s & h_seen_r & (cyc_cnt_r != 11'(H_TOTAL))) | timeout_s;
    // A coincident hsync edge belongs to the frame being closed.
    assign lines_s     = hs_edge_s ? sat_inc11(line_cnt_r) : line_cnt_r;
    assign frame_bad_s = frame_bad_r | line_bad_s | (v_seen_r & (lines_s != 11'(V_TOTAL)));

    // Input sync registers for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_d_r <= 1'b0;
            vs_d_r <= 1'b0;
        end else begin
            hs_d_r <= hsync_in;
            vs_d_r <= vsync_in;
        end
    end

    // Recovered raster position, re-anchored on every sync edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
        end else begin
            if (hs_edge_s) begin
                hcount_out <= 11'(H_SYNC_START);
            end else if (hcount_out == 11'(H_TOTAL - 1)) begin
                hcount_out <= 11'd0;
            end else begin
                hcount_out <= hcount_out + 11'd1;
            end
            if (vs_edge_s) begin
                vcount_out <= 11'(V_SYNC_START);
            end else if (h_wrap_s) begin
                if (vcount_out == 11'(V_TOTAL - 1)) begin
                    vcount_out <= 11'd0;
                end else begin
                    vcount_out <= vcount_out + 11'd1;
                end
            end
        end
    end

    // Line length measurement and hsync timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_r <= 11'd0;
            to_cnt_r  <= TO_W'(0);
            h_seen_r  <= 1'b0;
            h_total   <= 11'd0;
        end else if (hs_edge_s) begin
            cyc_cnt_r <= 11'd1;
            to_cnt_r  <= TO_W'(1);
            h_seen_r  <= 1'b1;
            if (h_seen_r) begin
                h_total <= cyc_cnt_r;
            end
        end else begin
            cyc_cnt_r <= sat_inc11(cyc_cnt_r);
            if (to_cnt_r <= TO_W'(TO_LIMIT)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end

    // Frame length measurement and per-frame bad-line accumulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_cnt_r  <= 11'd0;
            v_seen_r    <= 1'b0;
            frame_bad_r <= 1'b0;
            v_total     <= 11'd0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= vs_edge_s;
            if (vs_edge_s) begin
                line_cnt_r  <= 11'd0;
                v_seen_r    <= 1'b1;
                frame_bad_r <= 1'b0;
                if (v_seen_r) begin
                    v_total <= lines_s;
                end
            end else begin
                line_cnt_r <= lines_s;
                if (line_bad_s) begin
                    frame_bad_r <= 1'b1;
                end
            end
        end
    end

    // Lock state machine with registered locked/sync_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= SEARCH;
            good_cnt_r <= GC_W'(0);
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state_r)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vs_edge_s) begin
                        state_r    <= VERIFY;
                        good_cnt_r <= GC_W'(0);
                    end
                end
                VERIFY: begin
                    if (vs_edge_s) begin
                        if (frame_bad_s) begin
                            state_r <= SEARCH;
                        end else if (int'(good_cnt_r) + 1 >= LOCK_FRAMES) begin
                            state_r    <= LOCKED;
                            locked     <= 1'b1;
                            good_cnt_r <= GC_W'(0);
                        end else begin
                            good_cnt_r <= good_cnt_r + GC_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad_s || (vs_edge_s && frame_bad_s)) begin
                        state_r  <= SEARCH;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= SEARCH;
                    locked     <= 1'b0;
                    good_cnt_r <= GC_W'(0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a scaled-down raster (48x10) so
// whole frames fit in a short run; the 2047 saturation is still exercised.
module tb_vga_timing_decoder;

    localparam int H_T = 48;
    localparam int V_T = 10;
    localparam int HSS = 36;
    localparam int VSS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        frame_tick;
    logic        locked;
    logic        sync_err;

    int passed = 0;
    int total = 0;
    int fails = 0;
    int gh = 0;
    int gv = 0;
    int hlen = H_T;
    int vlen = V_T;
    bit hs_kill = 1'b0;
    int pgh = 0;
    int pgv = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int err_cnt = 0;
    int err_gh = -1;
    int err_cyc = 0;
    int tick_at_err = 0;
    int lock_rise_tick = -1;
    logic lock_rise_ft = 1'b0;
    logic locked_prev = 1'b0;
    int base = 0;
    int edge_cyc = 0;

    vga_timing_decoder #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_SYNC_START(HSS),
        .V_SYNC_START(VSS), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .h_total(h_total), .v_total(v_total),
        .frame_tick(frame_tick), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        hsync_in = !hs_kill && (gh >= HSS) && (gh < HSS + 4);
        vsync_in = (gv == VSS);
    endtask

    // One clock: sample DUT just after the edge, then advance the generator.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        pgh = gh;
        pgv = gv;
        if (frame_tick) tick_cnt = tick_cnt + 1;
        if (sync_err) begin
            err_cnt = err_cnt + 1;
            err_gh = pgh;
            err_cyc = cyc;
            tick_at_err = tick_cnt;
        end
        if (locked && !locked_prev) begin
            lock_rise_tick = tick_cnt;
            lock_rise_ft = frame_tick;
        end
        locked_prev = locked;
        if (gh >= hlen - 1) begin
            gh = 0;
            hlen = H_T;
            if (gv >= vlen - 1) begin
                gv = 0;
                vlen = V_T;
            end else begin
                gv = gv + 1;
            end
        end else begin
            gh = gh + 1;
        end
        drive();
    endtask

    task automatic run_to_tick(input int target, input string tag);
        for (int k = 0; k < 3000 && tick_cnt < target; k++) cycle();
        check(tag, tick_cnt, target);
    endtask

    task automatic seek(input int h, input int v, input string tag);
        for (int k = 0; k < 1000 && !(pgh == h && pgv == v); k++) cycle();
        check(tag, (pgh == h && pgv == v), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hcount"}, hcount_out, 0);
        check({tag, "_vcount"}, vcount_out, 0);
        check({tag, "_h_total"}, h_total, 0);
        check({tag, "_v_total"}, v_total, 0);
        check({tag, "_frame_tick"}, frame_tick, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_sync_err"}, sync_err, 0);
    endtask

    initial begin
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Nominal raster from reset: lock on the third vsync edge.
        run_to_tick(3, "lock_wait");
        check("lock_tick", lock_rise_tick, 3);
        check("lock_with_frame_tick", lock_rise_ft, 1);
        check("locked_nominal", locked, 1);
        check("h_total_nominal", h_total, H_T);
        check("v_total_nominal", v_total, V_T);
        check("no_sync_err_nominal", err_cnt, 0);

        // One full frame of position tracking, one clock behind the bus.
        for (int i = 0; i < H_T * V_T; i++) begin
            cycle();
            check("hcount_track", hcount_out, pgh);
            check("vcount_track", vcount_out, pgv);
        end

        // One short line while locked.
        hlen = H_T - 1;
        for (int k = 0; k < 200 && err_cnt < 1; k++) cycle();
        check("short_err_seen", err_cnt, 1);
        check("short_err_at_hsync", err_gh, HSS);
        check("short_unlocked", locked, 0);
        check("short_h_total", h_total, H_T - 1);
        cycle();
        check("short_err_single", err_cnt, 1);
        run_to_tick(tick_at_err + 3, "relock_wait");
        check("relock_tick", lock_rise_tick, tick_at_err + 3);
        check("relocked", locked, 1);

        // hsync stall: timeout after 2*H_T clocks, then saturated measurement.
        for (int k = 0; k < 100 && pgh != HSS; k++) cycle();
        check("stall_start_locked", locked, 1);
        edge_cyc = cyc;
        hs_kill = 1'b1;
        hsync_in = 1'b0;
        for (int k = 0; k < 300 && err_cnt < 2; k++) cycle();
        check("stall_err_seen", err_cnt, 2);
        check("stall_err_delay", err_cyc - edge_cyc, 2 * H_T);
        check("stall_unlocked", locked, 0);
        cycle();
        check("stall_err_single", err_cnt, 2);
        for (int k = 0; k < 2400 && !((cyc - edge_cyc >= 2200) && pgh == 0); k++) cycle();
        hs_kill = 1'b0;
        for (int k = 0; k < 60 && pgh != HSS; k++) cycle();
        check("stall_resume_edge", pgh, HSS);
        check("stall_h_total_sat", h_total, 2047);

        // Reset mid-line, then a 9-line frame while verifying.
        seek(10, 2, "seek_p5");
        rst = 1'b0;
        repeat (5) cycle();
        check("p5_in_reset_hcount", hcount_out, 0);
        rst = 1'b1;
        base = tick_cnt;
        run_to_tick(base + 1, "p5_tick1");
        vlen = V_T - 1;
        run_to_tick(base + 2, "p5_tick2");
        check("short_frame_v_total", v_total, V_T - 1);
        check("short_frame_unlocked", locked, 0);
        check("short_frame_no_err", err_cnt, 2);
        run_to_tick(base + 5, "p5_relock_wait");
        check("short_frame_relock_tick", lock_rise_tick, base + 5);
        check("short_frame_relocked", locked, 1);

        // Asynchronous reset while locked, then fresh lock.
        seek(20, 3, "seek_p6");
        check("p6_locked_before", locked, 1);
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (3) cycle();
        rst = 1'b1;
        base = tick_cnt;
        run_to_tick(base + 3, "p6_lock_wait");
        check("p6_lock_tick", lock_rise_tick, base + 3);
        check("p6_locked", locked, 1);
        check("p6_h_total", h_total, H_T);
        check("p6_v_total", v_total, V_T);
        check("p6_no_new_err", err_cnt, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
